// File: rtl/rst_req_gen.sv
`default_nettype none
// ============================================================================
//  Module   : rst_req_gen
//  Purpose  : Debounced push-button / power-on reset request source; produces
//             one clean active-low, minimum-width reset request.
//             Optional watchdog enabled by macro RST_REQ_GEN_WDOG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module rst_req_gen #(
    parameter int POR_CYCLES      = 1024,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 256,
    parameter int WDOG_CYCLES     = 16777216
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       key_in,
    input  logic       wdog_kick,
    output logic       rst_req_n,
    output logic [1:0] rst_cause,
    output logic [7:0] key_rst_cnt
);

    localparam int c_MAX_PD  = (POR_CYCLES > DEBOUNCE_CYCLES) ? POR_CYCLES : DEBOUNCE_CYCLES;
    localparam int c_CNT_MAX = (c_MAX_PD > PULSE_CYCLES) ? c_MAX_PD : PULSE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_POR_LAST  = c_CNT_W'(POR_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DB_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PULS_LAST = c_CNT_W'(PULSE_CYCLES - 1);

    localparam logic [2:0] c_ST_POR_HOLD = 3'd0;
    localparam logic [2:0] c_ST_RUN      = 3'd1;
    localparam logic [2:0] c_ST_PRESS_DB = 3'd2;
    localparam logic [2:0] c_ST_ASSERT   = 3'd3;
    localparam logic [2:0] c_ST_REL_DB   = 3'd4;

    localparam logic [1:0] c_CAUSE_POR  = 2'b00;
    localparam logic [1:0] c_CAUSE_KEY  = 2'b01;
    localparam logic [1:0] c_CAUSE_WDOG = 2'b10;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_key_meta;
    logic               r_key_s;
    logic               w_wdog_fire;

    // Raw button is asynchronous; idle level is released (1).
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_meta <= 1'b1;
            r_key_s    <= 1'b1;
        end else begin
            r_key_meta <= key_in;
            r_key_s    <= r_key_meta;
        end
    end

`ifdef RST_REQ_GEN_WDOG_EN
    localparam int                  c_WDOG_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_ONE  = c_WDOG_W'(1);

    logic [c_WDOG_W-1:0] r_wdog_cnt;
    logic                w_wdog_active;

    assign w_wdog_active = (r_state == c_ST_RUN) || (r_state == c_ST_PRESS_DB) ||
                           (r_state == c_ST_REL_DB);
    assign w_wdog_fire   = w_wdog_active && !wdog_kick && (r_wdog_cnt == c_WDOG_LAST);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
        end else if (!w_wdog_active || wdog_kick || w_wdog_fire) begin
            r_wdog_cnt <= '0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + c_WDOG_ONE;
        end
    end
`else
    logic w_unused;
    assign w_unused    = wdog_kick | (WDOG_CYCLES < 1);
    assign w_wdog_fire = 1'b0;
`endif

    // Watchdog expiry overrides any key transition taken in the same cycle.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_POR_HOLD;
            r_cnt       <= '0;
            rst_req_n   <= 1'b0;
            rst_cause   <= c_CAUSE_POR;
            key_rst_cnt <= 8'd0;
        end else if (w_wdog_fire) begin
            r_state   <= c_ST_ASSERT;
            r_cnt     <= '0;
            rst_req_n <= 1'b0;
            rst_cause <= c_CAUSE_WDOG;
        end else begin
            case (r_state)
                c_ST_POR_HOLD: begin
                    if (r_cnt == c_POR_LAST) begin
                        r_cnt     <= '0;
                        r_state   <= c_ST_RUN;
                        rst_req_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_RUN: begin
                    if (!r_key_s) begin
                        r_state <= c_ST_PRESS_DB;
                        r_cnt   <= '0;
                    end
                end
                c_ST_PRESS_DB: begin
                    if (r_key_s) begin
                        r_state <= c_ST_RUN;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_state   <= c_ST_ASSERT;
                        r_cnt     <= '0;
                        rst_req_n <= 1'b0;
                        rst_cause <= c_CAUSE_KEY;
                        if (key_rst_cnt != 8'hFF) begin
                            key_rst_cnt <= key_rst_cnt + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_ASSERT: begin
                    if (r_cnt == c_PULS_LAST) begin
                        r_state   <= c_ST_REL_DB;
                        r_cnt     <= '0;
                        rst_req_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_REL_DB: begin
                    // Any low sample restarts the release debounce, so a held key yields one pulse.
                    if (!r_key_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_state <= c_ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state   <= c_ST_POR_HOLD;
                    r_cnt     <= '0;
                    rst_req_n <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rst_req_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rst_req_gen
//  Purpose  : Directed self-checking bench for rst_req_gen
//             (POR=8, DEBOUNCE=4, PULSE=3, WDOG=32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rst_req_gen;

    logic       sys_clk;
    logic       rst_n;
    logic       key_in;
    logic       wdog_kick;
    logic       rst_req_n;
    logic [1:0] rst_cause;
    logic [7:0] key_rst_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int kick_per = 0;

`ifdef RST_REQ_GEN_WDOG_EN
    localparam int c_IDLE_LOWS   = 3;
    localparam int c_IDLE_PULSES = 1;
    localparam int c_IDLE_CAUSE  = 2;
`else
    localparam int c_IDLE_LOWS   = 0;
    localparam int c_IDLE_PULSES = 0;
    localparam int c_IDLE_CAUSE  = 0;
`endif

    rst_req_gen #(
        .POR_CYCLES     (8),
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES   (3),
        .WDOG_CYCLES    (32)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .wdog_kick  (wdog_kick),
        .rst_req_n  (rst_req_n),
        .rst_cause  (rst_cause),
        .key_rst_cnt(key_rst_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Samples rst_req_n on n falling edges, counting low samples and falling transitions.
    task automatic watch(input int n, inout int lows, inout int pulses);
        logic prev;
        prev = rst_req_n;
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            if (rst_req_n == 1'b0) lows++;
            if (prev == 1'b1 && rst_req_n == 1'b0) pulses++;
            prev = rst_req_n;
        end
    endtask

    // Cycles from the current falling edge until rst_req_n reads high (bounded).
    task automatic wait_high(output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (rst_req_n == 1'b0 && n < 50);
    endtask

    // Background kicker: one-cycle pulse every kick_per cycles when enabled.
    initial begin
        int kc;
        kc        = 0;
        wdog_kick = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (kick_per != 0 && kc >= kick_per - 1) begin
                wdog_kick = 1'b1;
                kc        = 0;
            end else begin
                wdog_kick = 1'b0;
                kc++;
            end
        end
    end

    initial begin
        int lows, pulses, n;
        rst_n  = 1'b0;
        key_in = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("reset_req_n", rst_req_n, 0);
        check("reset_cause", rst_cause, 0);
        check("reset_keycnt", key_rst_cnt, 0);

        // Power-on hold
        rst_n = 1'b1;
        wait_high(n);
        check("por_len", n, 8);
        check("por_cause", rst_cause, 0);
        check("por_keycnt", key_rst_cnt, 0);

        // Idle in RUN without kicks
        lows = 0; pulses = 0;
        watch(40, lows, pulses);
        check("idle_lows", lows, c_IDLE_LOWS);
        check("idle_pulses", pulses, c_IDLE_PULSES);
        check("idle_cause", rst_cause, c_IDLE_CAUSE);
        check("idle_keycnt", key_rst_cnt, 0);

        // Regular kicks keep the watchdog quiet
        kick_per = 20;
        lows = 0; pulses = 0;
        watch(80, lows, pulses);
        check("kick_lows", lows, 0);

        // 3-cycle glitch: no request
        lows = 0; pulses = 0;
        key_in = 1'b0;
        watch(3, lows, pulses);
        key_in = 1'b1;
        watch(12, lows, pulses);
        check("glitch_lows", lows, 0);
        check("glitch_keycnt", key_rst_cnt, 0);

        // Held press: one 3-cycle pulse
        lows = 0; pulses = 0;
        key_in = 1'b0;
        watch(20, lows, pulses);
        check("hold_lows", lows, 3);
        check("hold_pulses", pulses, 1);
        check("hold_cause", rst_cause, 1);
        check("hold_keycnt", key_rst_cnt, 1);

        // Bouncy release, then settled high: no request
        lows = 0; pulses = 0;
        key_in = 1'b1; watch(2, lows, pulses);
        key_in = 1'b0; watch(2, lows, pulses);
        key_in = 1'b1; watch(10, lows, pulses);
        check("bounce_lows", lows, 0);

        // Second stable press
        lows = 0; pulses = 0;
        key_in = 1'b0;
        watch(10, lows, pulses);
        check("press2_lows", lows, 3);
        check("press2_pulses", pulses, 1);
        check("press2_keycnt", key_rst_cnt, 2);

        // Third press, abort with rst_n during ASSERT
        key_in = 1'b1;
        watch(10, lows, pulses);
        key_in = 1'b0;
        n = 0;
        while (rst_req_n == 1'b1 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        check("abort_seen_low", (n < 20) ? 1 : 0, 1);
        check("abort_pre_keycnt", key_rst_cnt, 3);
        @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        check("abort_req_n", rst_req_n, 0);
        check("abort_keycnt", key_rst_cnt, 0);
        check("abort_cause", rst_cause, 0);
        key_in = 1'b1;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        wait_high(n);
        check("por2_len", n, 8);
        check("por2_keycnt", key_rst_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
